hoop_shot_judge: RTL
====================

// Module: hoop_shot_judge
// PURPOSE
//  Per-frame shot sequencer for the hoop/backboard/pole scene. Samples the ball centre once per
//  frame and runs the shot FSM (armed -> above rim -> through net / miss). Keeps the BCD score.
//  Drives the hoop rim colour: steady red normally, a red/white flash after a make.
//  Sits between the ball physics block and the hoop pixel renderer.
// PARAMETERS
//  HOOP_X_L        620  rim left x (inclusive), pixels
//  HOOP_X_R        630  rim right x (inclusive)
//  HOOP_Y_T         97  rim top y (inclusive)
//  HOOP_Y_B        100  rim bottom y (inclusive)
//  FLASH_FRAMES     32  frames spent in FLASH after a make (>=1)
//  TIMEOUT_FRAMES  600  frames allowed per shot before a forced miss (>=1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  frame_tick   in   1   one-cycle pulse once per frame (start of vblank)
//  shot_start   in   1   one-cycle pulse: ball released
//  ball_valid   in   1   ball on screen; sampled with ball_x/ball_y
//  ball_x       in  10   ball centre x, 0..639
//  ball_y       in  10   ball centre y, 0..479
//  score_bcd    out  8   {tens,units} BCD, 00..99
//  hoop_rgb     out 12   rim colour {R,G,B} for the hoop renderer
//  made_pulse   out  1   one-cycle pulse on a scored shot
//  miss_pulse   out  1   one-cycle pulse on a missed shot
//  streak       out  4   consecutive makes (0 when HOOP_STREAK_EN undefined)
//  busy         out  1   1 in ARMED, ABOVE, FLASH
// BEHAVIOUR
//  Reset: state=IDLE; score_bcd=8'h00; hoop_rgb=12'hF00; made_pulse=miss_pulse=0; streak=0;
//   frame counter=0. Reset mid-shot or mid-flash aborts immediately; no pulse is emitted.
//  in_x = HOOP_X_L<=ball_x<=HOOP_X_R. Ball inputs are used only on cycles with frame_tick=1.
//  All outputs are registered. Decisions take effect 1 clk after the deciding edge.
//  States:
//   IDLE : shot_start -> ARMED, frame counter cleared.
//   ARMED: on tick: !ball_valid or counter==TIMEOUT_FRAMES-1 -> MISS;
//          in_x && ball_y<HOOP_Y_T -> ABOVE; else count++.
//   ABOVE: on tick: !ball_valid or timeout -> MISS; in_x && ball_y>HOOP_Y_B -> MADE;
//          !in_x -> ARMED; else stay (count++). Timer is not reset.
//   MADE : one cycle. made_pulse=1; score += points; counter cleared -> FLASH.
//   MISS : one cycle. miss_pulse=1; streak=0 -> IDLE.
//   FLASH: on tick count++; hoop_rgb = counter[2] ? 12'hFFF : 12'hF00;
//          counter==FLASH_FRAMES-1 on tick -> IDLE, hoop_rgb=12'hF00.
//  Score: BCD add with carry units->tens. Saturates at 99 (partial add clamps to 99, never wraps).
//  Simultaneous events:
//   shot_start with frame_tick in IDLE: arm only; first evaluation is on the next tick.
//   shot_start in ARMED/ABOVE: restart as ARMED, counter=0, no miss_pulse.
//   shot_start in FLASH/MADE/MISS: ignored.
//   frame_tick in MADE/MISS: not counted.
//  A ball that drops straight through the rim band between two samples still scores,
//   because ABOVE is latched. Entry from below never scores.
// CONFIGURATION
//  HOOP_STREAK_EN defined: streak increments on MADE (saturates 15), clears on MISS.
//   points = 2 when the post-increment streak>=3, else 1.
//  HOOP_STREAK_EN undefined: no streak register; streak=4'd0; points always 1.
// TESTING
//  T1 reset mid-FLASH -> score_bcd=00, hoop_rgb=F00, busy=0 while reset high and after.
//  T2 make: shot_start; ticks with (625,60),(625,90),(625,110) -> made_pulse 1 clk after
//     3rd tick; score 00->01; FLASH toggles F00/FFF every 4 ticks, IDLE after 32 ticks.
//  T3 miss by timeout: shot_start, 600 ticks at (300,200) -> single miss_pulse on the 600th
//     evaluation; score unchanged; streak=0.
//  T4 off-screen + rim bounce: ABOVE at (625,90), next tick (600,110) -> ARMED (no score);
//     then ball_valid=0 -> miss_pulse.
//  T5 saturation: preload 98 via makes; with HOOP_STREAK_EN and streak>=2, next make -> 99
//     (not 00/100); further makes keep 99.
//  T6 streak (HOOP_STREAK_EN): makes 1,2,3,4 -> score 01,02,04,06; streak 1..4; a miss
//     clears streak; macro off -> 01,02,03,04, streak=0.

Source files
------------

// File: rtl/hoop_shot_judge_if.sv
// Ball-sample / score bundle between the ball physics block, the shot judge and the hoop renderer.
// master drives the per-frame ball samples and shot release; slave is the judge.
interface hoop_shot_judge_if;
  logic        frame_tick;
  logic        shot_start;
  logic        ball_valid;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [7:0]  score_bcd;
  logic [11:0] hoop_rgb;
  logic        made_pulse;
  logic        miss_pulse;
  logic [3:0]  streak;
  logic        busy;

  modport master (
    output frame_tick, shot_start, ball_valid, ball_x, ball_y,
    input  score_bcd, hoop_rgb, made_pulse, miss_pulse, streak, busy
  );

  modport slave (
    input  frame_tick, shot_start, ball_valid, ball_x, ball_y,
    output score_bcd, hoop_rgb, made_pulse, miss_pulse, streak, busy
  );
endinterface

// File: rtl/hoop_shot_judge.sv
// Per-frame shot sequencer: judges make/miss, keeps a saturating BCD score, flashes the rim after a make.
// All outputs registered, decisions visible 1 clk after the deciding edge; no backpressure. Option: HOOP_STREAK_EN.
module hoop_shot_judge #(
  parameter int unsigned HOOP_X_L       = 620,
  parameter int unsigned HOOP_X_R       = 630,
  parameter int unsigned HOOP_Y_T       = 97,
  parameter int unsigned HOOP_Y_B       = 100,
  parameter int unsigned FLASH_FRAMES   = 32,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic          clk,
  input  logic          reset,
  hoop_shot_judge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ABOVE,
    S_MADE,
    S_MISS,
    S_FLASH
  } state_t;

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_FRAMES - 1);
  localparam logic [CW-1:0] FLASH_LAST   = CW'(FLASH_FRAMES - 1);
  localparam logic [11:0]   RGB_RED      = 12'hF00;
  localparam logic [11:0]   RGB_WHITE    = 12'hFFF;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     score_q;
  logic [11:0]    rgb_q;
  logic           made_q;
  logic           miss_q;
  logic           busy_q;

  logic           in_x;
  logic           above_rim;
  logic           below_rim;
  logic [CW-1:0]  cnt_inc;
  logic [3:0]     points_d;
  logic [3:0]     units_sum;
  logic [3:0]     tens_sum;
  logic [7:0]     score_d;

  assign in_x      = (bus.ball_x >= 10'(HOOP_X_L)) && (bus.ball_x <= 10'(HOOP_X_R));
  assign above_rim = bus.ball_y < 10'(HOOP_Y_T);
  assign below_rim = bus.ball_y > 10'(HOOP_Y_B);
  assign cnt_inc   = cnt_q + CW'(1);

`ifdef HOOP_STREAK_EN
  logic [3:0] streak_q;
  logic [3:0] streak_d;

  assign streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
  assign points_d = (streak_d >= 4'd3) ? 4'd2 : 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= 4'd0;
    end else if (state_q == S_MADE) begin
      streak_q <= streak_d;
    end else if (state_q == S_MISS) begin
      streak_q <= 4'd0;
    end
  end

  assign bus.streak = streak_q;
`else
  assign points_d   = 4'd1;
  assign bus.streak = 4'd0;
`endif

  // Points never exceed 2, so one units carry suffices; a tens overflow clamps to 99.
  always_comb begin
    units_sum = score_q[3:0] + points_d;
    tens_sum  = score_q[7:4];
    if (units_sum > 4'd9) begin
      units_sum = units_sum - 4'd10;
      tens_sum  = tens_sum + 4'd1;
    end
    score_d = (tens_sum > 4'd9) ? 8'h99 : {tens_sum, units_sum};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      score_q <= 8'h00;
      rgb_q   <= RGB_RED;
      made_q  <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      made_q <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.shot_start) begin
            state_q <= S_ARMED;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_ARMED, S_ABOVE: begin
          if (bus.shot_start) begin
            state_q <= S_ARMED;
            cnt_q   <= '0;
          end else if (bus.frame_tick) begin
            if (!bus.ball_valid || (cnt_q == TIMEOUT_LAST)) begin
              state_q <= S_MISS;
              miss_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if ((state_q == S_ABOVE) && in_x && below_rim) begin
              state_q <= S_MADE;
              made_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // The shot timer keeps running across ARMED/ABOVE hops so a rim rattle cannot stall it.
              cnt_q <= cnt_inc;
              if ((state_q == S_ARMED) && in_x && above_rim) begin
                state_q <= S_ABOVE;
              end else if ((state_q == S_ABOVE) && !in_x) begin
                state_q <= S_ARMED;
              end
            end
          end
        end

        S_MADE: begin
          score_q <= score_d;
          cnt_q   <= '0;
          rgb_q   <= RGB_RED;
          state_q <= S_FLASH;
          busy_q  <= 1'b1;
        end

        S_MISS: begin
          state_q <= S_IDLE;
        end

        S_FLASH: begin
          if (bus.frame_tick) begin
            if (cnt_q == FLASH_LAST) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              rgb_q   <= RGB_RED;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
              rgb_q <= cnt_inc[2] ? RGB_WHITE : RGB_RED;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_bcd  = score_q;
  assign bus.hoop_rgb   = rgb_q;
  assign bus.made_pulse = made_q;
  assign bus.miss_pulse = miss_q;
  assign bus.busy       = busy_q;

endmodule
